// File: rtl/imem_loader.sv
// imem_loader
// ------------------------------------------------------------------------------
// Loads a program image, delivered one byte at a time, into a word-wide
// instruction memory. The CPU core is held in reset until a complete image
// is present. Bytes are big-endian within each 32-bit word: the first byte
// accepted lands in [31:24] and the fourth lands in [7:0].
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous, active-low reset (memory contents are kept)
//   start      one-cycle load request, honoured in IDLE and DONE only
//   byteValid  a loader byte is present on byteData
//   byteData   program byte
//   byteLast   byteData is the final byte of the image
//   byteReady  a byte is accepted this cycle (high only while loading)
//   pc         CPU fetch word index
//   instr      mem[pc], read combinationally
//   cpuRst     active-high hold reset to the CPU core (image not valid)
//   done       the last load completed and the image is valid
//   wordCount  number of words written by the current or last load
//   err        last load ended misaligned or ran past the end of memory
//   csum       running XOR of accepted bytes, or 8'h00 when not built
//
// Build option
//   IMEM_LOADER_CHECKSUM_EN  define to build the XOR checksum register.
//                            Without it csum is tied to zero.
// ------------------------------------------------------------------------------
module imem_loader #(
  parameter  int DEPTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          byteValid,
  input  logic [7:0]    byteData,
  input  logic          byteLast,
  output logic          byteReady,
  input  logic [AW-1:0] pc,
  output logic [31:0]   instr,
  output logic          cpuRst,
  output logic          done,
  output logic [CW-1:0] wordCount,
  output logic          err,
  output logic [7:0]    csum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [31:0] wordBuf;
  logic [31:0] assembled;
  logic        accept;
  logic        wrEn;
  logic        startLoad;
  logic [AW-1:0] wrIdx;

  logic [31:0] mem [DEPTH];

  // byteReady is only ever high in LOAD, so it doubles as the state qualifier
  // for accepting a byte.
  assign accept    = byteValid & byteReady;
  assign wrEn      = accept & ((lane == 2'd3) | byteLast);
  assign startLoad = start & ((state == IDLE) | (state == DONE));
  assign wrIdx     = wordCount[AW-1:0];

  // Merge the incoming byte into its lane. wordBuf is cleared at the start of
  // every word, so lanes not yet filled read as zero; this gives the zero-fill
  // for a short final word for free.
  always_comb begin
    assembled = wordBuf;
    case (lane)
      2'd0:    assembled[31:24] = byteData;
      2'd1:    assembled[23:16] = byteData;
      2'd2:    assembled[15:8]  = byteData;
      default: assembled[7:0]   = byteData;
    endcase
  end

  // Main control FSM. Outputs byteReady/cpuRst/done are registered and change
  // together with the state, so cpuRst reasserts the cycle after a restart
  // from DONE. A word is committed on the 4th byte or on byteLast; the load
  // also stops once the final memory word has been written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      byteReady <= 1'b0;
      cpuRst    <= 1'b1;
      done      <= 1'b0;
      wordCount <= '0;
      err       <= 1'b0;
      lane      <= 2'd0;
      wordBuf   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startLoad) begin
            state     <= LOAD;
            byteReady <= 1'b1;
            cpuRst    <= 1'b1;
            done      <= 1'b0;
            wordCount <= '0;
            err       <= 1'b0;
            lane      <= 2'd0;
            wordBuf   <= '0;
          end
        end

        LOAD: begin
          if (accept) begin
            if (wrEn) begin
              wordCount <= wordCount + CW'(1);
              lane      <= 2'd0;
              wordBuf   <= '0;
              if (byteLast || (wordCount == CW'(DEPTH - 1))) begin
                if (!byteLast || (lane != 2'd3)) begin
                  err <= 1'b1;
                end
                state     <= DONE;
                byteReady <= 1'b0;
                cpuRst    <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              wordBuf <= assembled;
              lane    <= lane + 2'd1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          byteReady <= 1'b0;
          cpuRst    <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Instruction memory has no reset: an image survives a reset, and words a
  // new load does not reach keep their previous contents.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= assembled;
    end
  end

  assign instr = mem[pc];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csumReg;

  // Running XOR of every byte accepted since the load started; it naturally
  // freezes in DONE because no bytes are accepted there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csumReg <= 8'h00;
    end else if (startLoad) begin
      csumReg <= 8'h00;
    end else if (accept) begin
      csumReg <= csumReg ^ byteData;
    end
  end

  assign csum = csumReg;
`else
  assign csum = 8'h00;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction memory size in 32-bit words; the word index is 6 bits at the default.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a program load; sampled in IDLE and DONE only.
REQ-005 byteValid  input  1  a loader byte is present on byteData.
REQ-006 byteData  input  8  program byte, big-endian within each word.
REQ-007 byteLast  input  1  qualifies byteData as the final byte of the image.
REQ-008 byteReady  output  1  the block accepts a byte this cycle.
REQ-009 pc  input  6  CPU fetch word index (the byte PC with its low two bits dropped).
REQ-010 instr  output  32  instruction word at index pc.
REQ-011 cpuRst  output  1  active-high hold reset to the CPU core; asserted whenever the image is not valid.
REQ-012 done  output  1  a load has completed and the image is valid.
REQ-013 wordCount  output  7  number of words written in the current or last load.
REQ-014 err  output  1  sticky flag: the last load ended misaligned or overran DEPTH.
REQ-015 csum  output  8  XOR checksum of the accepted bytes (see Configuration).

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-017 IDLE: byteReady=0, cpuRst=1, done=0; start moves the FSM to LOAD.
REQ-018 On entry to LOAD the block SHALL clear the byte lane counter, wordCount, err and csum.
REQ-019 LOAD: byteReady=1; a byte is accepted only when byteValid&byteReady are both high on a clock edge.
REQ-020 Accepted bytes fill lanes [31:24], [23:16], [15:8] and [7:0] in that order.
REQ-021 When the 4th byte is accepted, the block SHALL write the assembled word to mem[wordCount] on that edge and increment wordCount.
REQ-022 A byteLast on lane 3 SHALL complete the word normally, then the FSM moves to DONE with err unchanged.
REQ-023 A byteLast on lanes 0-2 SHALL zero-fill the remaining lanes, write the word, increment wordCount, set err=1 and move the FSM to DONE.
REQ-024 When word DEPTH-1 is written without byteLast, the FSM SHALL move to DONE with err=1; later bytes are not accepted.
REQ-025 DONE: byteReady=0, cpuRst=0, done=1; start returns the FSM to LOAD, and cpuRst reasserts on the following cycle.
REQ-026 instr SHALL equal mem[pc] combinationally in every state; a write and a read to the same index in one cycle shows the old word until the edge.
REQ-027 Words not written by the current load SHALL retain their prior contents; memory is never cleared.
REQ-028 byteValid low in LOAD SHALL stall the load indefinitely with no state change.
REQ-029 start asserted while in LOAD SHALL be ignored.

Reset
REQ-030 Asserting rst low at any time, including mid-load, SHALL immediately force IDLE, byteReady=0, cpuRst=1, done=0, wordCount=0, err=0, csum=0, lane=0, without waiting for clk.
REQ-031 Reset SHALL NOT alter memory contents; a partially assembled word is discarded.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN controls the checksum: when defined, csum is the running XOR of all bytes accepted since entering LOAD, held stable in DONE.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, csum SHALL be tied to 8'h00 and no checksum register is built.

Verification
REQ-034 Load bytes 20,08,00,05 with byteLast on the 4th -> mem[0]=32'h20080005, wordCount=1, done=1, err=0, cpuRst=0; pc=0 gives instr=32'h20080005.
REQ-035 Load bytes AA,BB with byteLast on BB -> mem[0]=32'hAABB0000, wordCount=1, err=1, done=1.
REQ-036 Stream 64 words with no byteLast and byteValid held high -> DONE after word 63, err=1, byteReady=0 on the next cycle, the 257th byte is not accepted.
REQ-037 Pull rst low after 6 accepted bytes -> IDLE, wordCount=0, cpuRst=1; mem[0] keeps the word from the first 4 bytes; start then reloads from index 0.
REQ-038 With IMEM_LOADER_CHECKSUM_EN, load 01,02,04,08 (last) -> csum=8'h0F; without the macro -> csum=8'h00; toggling byteValid every other cycle gives the same mem and csum results.
